// File: rtl/sound_ctrl.sv
// sound_ctrl: byte-wide register front end for an SN76477-style sound
// generator. Multi-byte frequencies are staged and committed atomically on
// the high-byte write; a two-state note FSM gates the mixer with a
// prescaled duration timer and pulses done on natural expiry.
module sound_ctrl #(
    parameter int DIV_TICK = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  addr,
    input  logic [7:0]  wr_data,
    output logic [11:0] vco1_freq,
    output logic [11:0] vco2_freq,
    output logic [11:0] noise_freq,
    output logic [9:0]  lfo_freq,
    output logic        vco1_select,
    output logic        vco2_select,
    output logic        noise_select,
    output logic [2:0]  lfo_shift,
    output logic [3:0]  mixer,
    output logic        playing,
    output logic        done
);

    localparam int PW = $clog2(DIV_TICK);
    localparam logic [PW-1:0] PRE_RELOAD = PW'(DIV_TICK - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PLAYING = 1'b1
    } state_e;

    state_e        state_q,       state_d;
    logic [7:0]    vco1_lo_q,     vco1_lo_d;
    logic [7:0]    vco2_lo_q,     vco2_lo_d;
    logic [7:0]    noise_lo_q,    noise_lo_d;
    logic [7:0]    lfo_lo_q,      lfo_lo_d;
    logic [11:0]   vco1_freq_q,   vco1_freq_d;
    logic [11:0]   vco2_freq_q,   vco2_freq_d;
    logic [11:0]   noise_freq_q,  noise_freq_d;
    logic [9:0]    lfo_freq_q,    lfo_freq_d;
    logic [5:0]    sel_q,         sel_d;
    logic [3:0]    mixer_stage_q, mixer_stage_d;
    logic [7:0]    duration_q,    duration_d;
    logic [3:0]    mixer_q,       mixer_d;
    logic          playing_q,     playing_d;
    logic          done_q,        done_d;
    logic [PW-1:0] pre_q,         pre_d;
    logic [7:0]    dur_q,         dur_d;

    logic          cmd_wr_s;
    logic          start_s;
    logic          stop_s;
    logic          mix_wr_s;

    // Command decode: stop takes priority over start when both bits are set.
    always_comb begin
        cmd_wr_s = wr_en && (addr == 4'd11);
        stop_s   = cmd_wr_s && wr_data[1];
        start_s  = cmd_wr_s && wr_data[0] && !wr_data[1];
        mix_wr_s = wr_en && (addr == 4'd9);
    end

    // Register-file writes: low bytes stage, high-byte writes commit the full word.
    always_comb begin
        vco1_lo_d     = vco1_lo_q;
        vco2_lo_d     = vco2_lo_q;
        noise_lo_d    = noise_lo_q;
        lfo_lo_d      = lfo_lo_q;
        vco1_freq_d   = vco1_freq_q;
        vco2_freq_d   = vco2_freq_q;
        noise_freq_d  = noise_freq_q;
        lfo_freq_d    = lfo_freq_q;
        sel_d         = sel_q;
        mixer_stage_d = mixer_stage_q;
        duration_d    = duration_q;
        if (wr_en) begin
            case (addr)
                4'd0:    vco1_lo_d     = wr_data;
                4'd1:    vco1_freq_d   = {wr_data[3:0], vco1_lo_q};
                4'd2:    vco2_lo_d     = wr_data;
                4'd3:    vco2_freq_d   = {wr_data[3:0], vco2_lo_q};
                4'd4:    noise_lo_d    = wr_data;
                4'd5:    noise_freq_d  = {wr_data[3:0], noise_lo_q};
                4'd6:    lfo_lo_d      = wr_data;
                4'd7:    lfo_freq_d    = {wr_data[1:0], lfo_lo_q};
                4'd8:    sel_d         = wr_data[5:0];
                4'd9:    mixer_stage_d = wr_data[3:0];
                4'd10:   duration_d    = wr_data;
                default: sel_d         = sel_q;
            endcase
        end else begin
            sel_d = sel_q;
        end
    end

    // Note FSM: start/stop handling, prescaler and duration countdown, mixer gating.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        dur_d   = dur_q;
        mixer_d = mixer_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_PLAYING;
                    mixer_d = mixer_stage_q;
                    dur_d   = duration_q;
                    pre_d   = PRE_RELOAD;
                end else begin
                    mixer_d = 4'd0;
                end
            end
            ST_PLAYING: begin
                if (stop_s) begin
                    state_d = ST_IDLE;
                    mixer_d = 4'd0;
                    dur_d   = 8'd0;
                end else if (start_s) begin
                    // Restart wins over a same-cycle expiry, so no done pulse.
                    mixer_d = mixer_stage_q;
                    dur_d   = duration_q;
                    pre_d   = PRE_RELOAD;
                end else begin
                    if (mix_wr_s) begin
                        mixer_d = wr_data[3:0];
                    end else begin
                        mixer_d = mixer_q;
                    end
                    // A zero duration freezes both counters: play until stopped.
                    if (dur_q != 8'd0) begin
                        if (pre_q == '0) begin
                            pre_d = PRE_RELOAD;
                            if (dur_q == 8'd1) begin
                                state_d = ST_IDLE;
                                mixer_d = 4'd0;
                                dur_d   = 8'd0;
                                done_d  = 1'b1;
                            end else begin
                                dur_d = dur_q - 8'd1;
                            end
                        end else begin
                            pre_d = pre_q - PW'(1);
                        end
                    end else begin
                        pre_d = pre_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                mixer_d = 4'd0;
            end
        endcase
        playing_d = (state_d == ST_PLAYING);
    end

    // State and register bank with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            vco1_lo_q     <= 8'd0;
            vco2_lo_q     <= 8'd0;
            noise_lo_q    <= 8'd0;
            lfo_lo_q      <= 8'd0;
            vco1_freq_q   <= 12'd0;
            vco2_freq_q   <= 12'd0;
            noise_freq_q  <= 12'd0;
            lfo_freq_q    <= 10'd0;
            sel_q         <= 6'd0;
            mixer_stage_q <= 4'd0;
            duration_q    <= 8'd0;
            mixer_q       <= 4'd0;
            playing_q     <= 1'b0;
            done_q        <= 1'b0;
            pre_q         <= '0;
            dur_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            vco1_lo_q     <= vco1_lo_d;
            vco2_lo_q     <= vco2_lo_d;
            noise_lo_q    <= noise_lo_d;
            lfo_lo_q      <= lfo_lo_d;
            vco1_freq_q   <= vco1_freq_d;
            vco2_freq_q   <= vco2_freq_d;
            noise_freq_q  <= noise_freq_d;
            lfo_freq_q    <= lfo_freq_d;
            sel_q         <= sel_d;
            mixer_stage_q <= mixer_stage_d;
            duration_q    <= duration_d;
            mixer_q       <= mixer_d;
            playing_q     <= playing_d;
            done_q        <= done_d;
            pre_q         <= pre_d;
            dur_q         <= dur_d;
        end
    end

    assign vco1_freq    = vco1_freq_q;
    assign vco2_freq    = vco2_freq_q;
    assign noise_freq   = noise_freq_q;
    assign lfo_freq     = lfo_freq_q;
    assign noise_select = sel_q[5];
    assign vco2_select  = sel_q[4];
    assign vco1_select  = sel_q[3];
    assign lfo_shift    = sel_q[2:0];
    assign mixer        = mixer_q;
    assign playing      = playing_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sound_ctrl.sv
// Testbench for sound_ctrl: register-write vector table, hand-written note
// sequences, and randomized traffic checked against a cycle-count model.
module tb_sound_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  addr;
    logic [7:0]  wr_data;
    logic [11:0] vco1_freq, vco2_freq, noise_freq;
    logic [9:0]  lfo_freq;
    logic        vco1_select, vco2_select, noise_select;
    logic [2:0]  lfo_shift;
    logic [3:0]  mixer;
    logic        playing, done;

    sound_ctrl #(.DIV_TICK(DIV)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
        .vco1_freq(vco1_freq), .vco2_freq(vco2_freq), .noise_freq(noise_freq),
        .lfo_freq(lfo_freq), .vco1_select(vco1_select), .vco2_select(vco2_select),
        .noise_select(noise_select), .lfo_shift(lfo_shift), .mixer(mixer),
        .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0]  m_lo1, m_lo2, m_lon, m_lol;
    logic [11:0] m_v1, m_v2, m_nz;
    logic [9:0]  m_lfo;
    logic [5:0]  m_sel;
    logic [3:0]  m_stage, m_mixer;
    logic [7:0]  m_dur;
    logic        m_playing, m_done, m_inf;
    int          m_rem;

    typedef struct {
        logic [3:0]  a;
        logic [7:0]  d;
        int          which;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lo1 = 8'd0; m_lo2 = 8'd0; m_lon = 8'd0; m_lol = 8'd0;
        m_v1 = 12'd0; m_v2 = 12'd0; m_nz = 12'd0; m_lfo = 10'd0;
        m_sel = 6'd0; m_stage = 4'd0; m_mixer = 4'd0; m_dur = 8'd0;
        m_playing = 1'b0; m_done = 1'b0; m_inf = 1'b0; m_rem = 0;
    endtask

    // Note timing modelled as a remaining-cycle count of duration*DIV.
    task automatic model_step(input logic w, input logic [3:0] a, input logic [7:0] d);
        logic is_cmd, start, stop;
        is_cmd = w && (a == 4'd11);
        stop   = is_cmd && d[1];
        start  = is_cmd && d[0] && !d[1];
        m_done = 1'b0;
        if (stop) begin
            m_playing = 1'b0;
            m_mixer   = 4'd0;
        end else if (start) begin
            m_playing = 1'b1;
            m_mixer   = m_stage;
            m_rem     = int'(m_dur) * DIV;
            m_inf     = (m_dur == 8'd0);
        end else if (m_playing) begin
            if (w && a == 4'd9) m_mixer = d[3:0];
            if (!m_inf) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_playing = 1'b0;
                    m_mixer   = 4'd0;
                    m_done    = 1'b1;
                end
            end
        end
        if (w) begin
            case (a)
                4'd0:    m_lo1 = d;
                4'd1:    m_v1 = 12'(int'(d[3:0]) * 256 + int'(m_lo1));
                4'd2:    m_lo2 = d;
                4'd3:    m_v2 = 12'(int'(d[3:0]) * 256 + int'(m_lo2));
                4'd4:    m_lon = d;
                4'd5:    m_nz = 12'(int'(d[3:0]) * 256 + int'(m_lon));
                4'd6:    m_lol = d;
                4'd7:    m_lfo = 10'(int'(d[1:0]) * 256 + int'(m_lol));
                4'd8:    m_sel = d[5:0];
                4'd9:    m_stage = d[3:0];
                4'd10:   m_dur = d;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic w, input logic [3:0] a, input logic [7:0] d);
        wr_en = w; addr = a; wr_data = d;
        @(posedge clk);
        model_step(w, a, d);
        #1;
        wr_en = 1'b0; addr = 4'd0; wr_data = 8'd0;
    endtask

    function automatic logic [57:0] dut_vec();
        return {vco1_freq, vco2_freq, noise_freq, lfo_freq, noise_select, vco2_select,
                vco1_select, lfo_shift, mixer, playing, done};
    endfunction

    function automatic logic [57:0] model_vec();
        return {m_v1, m_v2, m_nz, m_lfo, m_sel, m_mixer, m_playing, m_done};
    endfunction

    function automatic logic [11:0] get_out(input int which);
        case (which)
            0: return vco1_freq;
            1: return vco2_freq;
            2: return noise_freq;
            3: return {2'b00, lfo_freq};
            4: return {6'd0, noise_select, vco2_select, vco1_select, lfo_shift};
            default: return {8'd0, mixer};
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset = 1'b0; wr_en = 1'b0; addr = 4'd0; wr_data = 8'd0;
        model_reset();

        // Reset held with write traffic: nothing may change
        for (int i = 0; i < 6; i++) begin
            wr_en = ~wr_en; addr = 4'(i + 7); wr_data = 8'hFF;
            @(posedge clk); #1;
        end
        check("reset_hold", {6'd0, dut_vec()}, 64'd0);
        wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        tbl[0]  = '{4'd8,  8'h2D, 4, 12'h02D};
        tbl[1]  = '{4'd0,  8'h34, 0, 12'h000};
        tbl[2]  = '{4'd1,  8'hF2, 0, 12'h234};
        tbl[3]  = '{4'd1,  8'h05, 0, 12'h534};
        tbl[4]  = '{4'd2,  8'hAB, 1, 12'h000};
        tbl[5]  = '{4'd3,  8'hFC, 1, 12'hCAB};
        tbl[6]  = '{4'd4,  8'h11, 2, 12'h000};
        tbl[7]  = '{4'd5,  8'h37, 2, 12'h711};
        tbl[8]  = '{4'd6,  8'hFF, 3, 12'h000};
        tbl[9]  = '{4'd7,  8'hFE, 3, 12'h2FF};
        tbl[10] = '{4'd12, 8'hFF, 4, 12'h02D};
        tbl[11] = '{4'd15, 8'h00, 0, 12'h534};
        tbl[12] = '{4'd8,  8'hC0, 4, 12'h000};
        tbl[13] = '{4'd9,  8'h0B, 5, 12'h000};
        for (int i = 0; i < 14; i++) begin
            step(1'b1, tbl[i].a, tbl[i].d);
            check($sformatf("vec%0d", i), {52'd0, get_out(tbl[i].which)}, {52'd0, tbl[i].exp});
        end

        // Timed note: 3 ticks of 4 cycles
        step(1'b1, 4'd10, 8'd3);
        step(1'b1, 4'd11, 8'h01);
        check("note_start", {61'd0, mixer, playing, done}, {61'd0, 4'hB, 1'b1, 1'b0});
        bad = 0;
        for (int i = 1; i < 12; i++) begin
            step(1'b0, 4'd0, 8'd0);
            if ({mixer, playing, done} !== {4'hB, 1'b1, 1'b0}) bad++;
        end
        check("note_hold", bad, 0);
        step(1'b0, 4'd0, 8'd0);
        check("note_expire", {61'd0, mixer, playing, done}, {61'd0, 4'h0, 1'b0, 1'b1});
        step(1'b0, 4'd0, 8'd0);
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // Indefinite note, then start+stop together: stop wins
        step(1'b1, 4'd10, 8'd0);
        step(1'b1, 4'd11, 8'h01);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 4'd0, 8'd0);
            if (!playing || done) bad++;
        end
        check("infinite_note", bad, 0);
        step(1'b1, 4'd11, 8'h03);
        check("stop_priority", {61'd0, mixer, playing, done}, 64'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'd0, 8'd0);
            if (done) bad++;
        end
        check("stop_no_done", bad, 0);

        // Restart at cycle 10 of a 12-cycle note
        step(1'b1, 4'd10, 8'd3);
        step(1'b1, 4'd11, 8'h01);
        for (int i = 1; i < 10; i++) step(1'b0, 4'd0, 8'd0);
        step(1'b1, 4'd11, 8'h01);
        check("restart", {62'd0, playing, done}, {62'd0, 1'b1, 1'b0});
        bad = 0;
        for (int i = 1; i < 12; i++) begin
            step(1'b0, 4'd0, 8'd0);
            if (!playing || done) bad++;
        end
        check("restart_hold", bad, 0);
        step(1'b0, 4'd0, 8'd0);
        check("restart_expire", {62'd0, playing, done}, {62'd0, 1'b0, 1'b1});

        // Live mixer update, then asynchronous reset mid-note
        step(1'b1, 4'd10, 8'd0);
        step(1'b1, 4'd11, 8'h01);
        step(1'b1, 4'd9, 8'h04);
        check("live_mixer", {59'd0, mixer, playing}, {59'd0, 4'h4, 1'b1});
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {6'd0, dut_vec()}, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        check("model_sync", {6'd0, dut_vec()}, {6'd0, model_vec()});

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic        w;
            logic [3:0]  a;
            logic [7:0]  d;
            w = ($urandom_range(0, 3) != 0);
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            if (a == 4'd10) d = 8'($urandom_range(0, 4));
            if (a == 4'd11) d = 8'($urandom_range(0, 3));
            step(w, a, d);
            check($sformatf("rand%0d", i), {6'd0, dut_vec()}, {6'd0, model_vec()});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sound_ctrl.md
# sound_ctrl

Register-programmed controller that drives the control inputs of the SN76477-style sound generator: VCO, noise and LFO frequencies, modulation selects, LFO depth and mixer enables. A CPU or test sequencer writes byte-wide registers over a simple write strobe. The block commits multi-byte frequencies atomically and gates the mixer with a note-duration timer. It sits between the system bus and the sound generator; every output is registered and wires directly to the generator's same-named inputs.

## Interface
- DIV_TICK, 250000: clk cycles per duration tick (10 ms at 25 MHz); legal ≥ 2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe, one write per cycle it is high
- addr  in  4  register address
- wr_data  in  8  write data
- vco1_freq / vco2_freq / noise_freq  out  12 each  committed frequencies
- lfo_freq  out  10  committed LFO frequency
- vco1_select / vco2_select / noise_select  out  1 each  LFO modulation enables
- lfo_shift  out  3  LFO modulation depth
- mixer  out  4  {LFO, Noise, VCO2, VCO1} enables; forced 0 when not playing
- playing  out  1  note in progress
- done  out  1  one-cycle pulse on natural duration expiry

## Operation
- Reset (reset=0): all outputs 0, all staging registers 0, state IDLE, prescaler and duration counter 0. Asynchronous assert, synchronous release.
- Register map (write-only; writes to addr 12–15 are ignored):
  - 0/2/4: low byte of vco1/vco2/noise frequency into a staging register; the output does not change.
  - 1/3/5: wr_data[3:0] is the high nibble. The output frequency becomes {wr_data[3:0], staged low byte} in a single update. wr_data[7:4] is ignored.
  - 6: LFO low byte, staged.
  - 7: wr_data[1:0] is the high bits. Commits lfo_freq = {wr_data[1:0], staged low}.
  - 8: directly sets {noise_select, vco2_select, vco1_select, lfo_shift} = wr_data[5:0]. Bits [7:6] are ignored.
  - 9: mixer_stage = wr_data[3:0]. If PLAYING, mixer also updates the following cycle.
  - 10: duration = wr_data, in ticks. 0 means play until stopped.
  - 11: command register. bit0 = start, bit1 = stop. If both bits are set, stop wins.
- A staged low byte persists until overwritten, so a repeated high-byte write recommits the same low byte.
- FSM states: IDLE, PLAYING.
  - IDLE + start → PLAYING. Actions: mixer ← mixer_stage; dur_cnt ← duration; prescaler ← DIV_TICK−1; playing ← 1.
  - PLAYING + start → restart. Counters reload as above; done does not pulse.
  - PLAYING + stop → IDLE. mixer ← 0, playing ← 0, done stays 0.
  - IDLE + stop → no effect.
  - PLAYING with dur_cnt≠0: the prescaler decrements every cycle. At prescaler 0 it reloads DIV_TICK−1 and dur_cnt decrements. When dur_cnt goes 1→0 → IDLE, mixer ← 0, playing ← 0, done ← 1 for one cycle.
  - PLAYING with duration=0 at start: counters are frozen and the note plays indefinitely.
- Frequency/select writes are accepted in either state and take effect immediately. They do not affect timing.
- Writing duration (addr 10) while PLAYING affects only the next start.

## Timing
- A write sampled at posedge N is visible on the outputs after posedge N (registered, 1-cycle latency).
- Start written at edge N → playing=1 from edge N. playing stays high for exactly duration×DIV_TICK cycles, then falls.
- done is high for exactly the one cycle in which playing first reads 0 after a natural expiry.
- Stop written at edge N → playing=0 and mixer=0 from edge N.
- A start and the expiry in the same cycle: start wins. The block restarts and done stays 0.
- Reset asserted mid-note: immediate return to reset values. No done pulse.
- Width rules: the prescaler is sized to hold DIV_TICK−1. dur_cnt is 8 bits and never wraps below 0.

## Test plan
- Reset: hold reset=0 with wr_en toggling → every output 0. Release reset; the first write to addr 8 with 0x2D takes effect → noise_select=1, vco2_select=0, vco1_select=1, lfo_shift=5.
- Atomic commit: write addr0=0x34 → vco1_freq stays 0. Write addr1=0xF2 → vco1_freq=0x234 after one edge. Write addr1=0x05 → 0x534.
- Timed note (DIV_TICK=4): addr9=0xB, addr10=3, addr11=0x01 → mixer=0xB and playing=1 for exactly 12 cycles. Then mixer=0, playing=0, done=1 for one cycle.
- Stop/priority: start with duration 0 and wait 100 cycles → still playing. Write addr11=0x03 → playing=0 on the next edge; done never pulses.
- Restart: issue start at cycle 10 of a 12-cycle note → playing stays high for 12 cycles from the restart; no done pulse at the original expiry.
- Live mixer and async reset: while PLAYING, write addr9=0x4 → mixer=0x4 the next cycle. Pulse reset=0 mid-note → playing=0 and mixer=0 immediately, without waiting for a clock edge.
